// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings on the
// {cs_n, ras_n, cas_n, we_n} pins and the one-hot command-bus arbiter states.
package sdram_pkg;

    // Device commands, {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_MRS        = 4'b0000;
    localparam logic [3:0] CMD_AREF       = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_WRITE      = 4'b0100;
    localparam logic [3:0] CMD_READ       = 4'b0101;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [3:0] CMD_NOP        = 4'b0111;

    // Arbiter states, one-hot
    localparam logic [4:0] ST_INIT  = 5'b00001;
    localparam logic [4:0] ST_ARBIT = 5'b00010;
    localparam logic [4:0] ST_AREF  = 5'b00100;
    localparam logic [4:0] ST_WRITE = 5'b01000;
    localparam logic [4:0] ST_READ  = 5'b10000;

endpackage

// File: rtl/sdram_arbit.sv
// Command-bus arbiter: runs power-up init, then grants the shared SDRAM
// command/address bus to the refresh, write or read engine (ref > wr > rd)
// through an ask/en/end handshake and muxes the owner onto the pins.
// Optional build macro SDRAM_ARB_RR_EN: write and read alternate when both
// ask in the same arbitration cycle (refresh keeps top priority).
module sdram_arbit
#(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic        sclk,
    input  logic        srst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        ref_ask,
    input  logic        ref_end,
    input  logic [3:0]  ref_cmd,
    input  logic [11:0] ref_addr,
    input  logic        wr_ask,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic        rd_ask,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    output logic        ref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        ref_pending,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr
);

    // Only the state encodings are pulled in; CMD_NOP is the local parameter.
    import sdram_pkg::ST_INIT;
    import sdram_pkg::ST_ARBIT;
    import sdram_pkg::ST_AREF;
    import sdram_pkg::ST_WRITE;
    import sdram_pkg::ST_READ;

    logic [4:0] r_state;
    logic [4:0] w_next_state;
    logic       w_wr_wins;
    logic       r_ref_en;
    logic       r_wr_en;
    logic       r_rd_en;
    logic       r_cke;

`ifdef SDRAM_ARB_RR_EN
    logic r_last_wr;

    // Remember which of write/read was granted last so a tie goes to the other
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_last_wr <= 1'b0;
        end else if (r_state == ST_ARBIT) begin
            if (w_next_state == ST_WRITE) begin
                r_last_wr <= 1'b1;
            end else if (w_next_state == ST_READ) begin
                r_last_wr <= 1'b0;
            end
        end
    end

    assign w_wr_wins = wr_ask & (~rd_ask | ~r_last_wr);
`else
    assign w_wr_wins = wr_ask;
`endif

    // Next-state logic: init handoff, priority pick in ARBIT, release on x_end
    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_INIT: begin
                if (init_end) w_next_state = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (ref_ask) begin
                    w_next_state = ST_AREF;
                end else if (w_wr_wins) begin
                    w_next_state = ST_WRITE;
                end else if (rd_ask) begin
                    w_next_state = ST_READ;
                end
            end
            ST_AREF: begin
                if (ref_end) w_next_state = ST_ARBIT;
            end
            ST_WRITE: begin
                if (wr_end) w_next_state = ST_ARBIT;
            end
            ST_READ: begin
                if (rd_end) w_next_state = ST_ARBIT;
            end
            // Illegal one-hot codes fall back to a fresh initialisation
            default: w_next_state = ST_INIT;
        endcase
    end

    // State register
    always_ff @(posedge sclk or negedge srst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!srst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered grants track the state one-to-one; cke rises once after reset
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_ref_en <= 1'b0;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_cke    <= 1'b0;
        end else begin
            r_ref_en <= (w_next_state == ST_AREF);
            r_wr_en  <= (w_next_state == ST_WRITE);
            r_rd_en  <= (w_next_state == ST_READ);
            r_cke    <= 1'b1;
        end
    end

    // Bus mux: exactly one source per state, NOP/0 while arbitrating
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 12'd0;
        case (r_state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = 12'd0;
            end
        endcase
    end

    // A refresh waiting behind a data burst asks the owner to finish early
    assign ref_pending = ref_ask & ((r_state == ST_WRITE) | (r_state == ST_READ));

    assign ref_en    = r_ref_en;
    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign sdram_cke = r_cke;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios with literal expectations, then
// randomized traffic, all shadowed by a bus-ownership model checked every
// falling edge. Honours SDRAM_ARB_RR_EN when the build defines it.
`timescale 1ns/1ps
module tb_sdram_arbit;

    localparam logic [3:0] NOP = 4'b0111;
    localparam int O_INIT = 0;
    localparam int O_IDLE = 1;
    localparam int O_REF  = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        sclk = 1'b0;
    logic        srst_n = 1'b0;
    logic        init_end = 1'b0;
    logic [3:0]  init_cmd = 4'b0000;
    logic [11:0] init_addr = 12'h400;
    logic        ref_ask = 1'b0, ref_end = 1'b0;
    logic [3:0]  ref_cmd = 4'b0001;
    logic [11:0] ref_addr = 12'h000;
    logic        wr_ask = 1'b0, wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'b0100;
    logic [11:0] wr_addr = 12'h123;
    logic        rd_ask = 1'b0, rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'b0101;
    logic [11:0] rd_addr = 12'h456;
    logic        ref_en, wr_en, rd_en, ref_pending, sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_arbit #(.CMD_NOP(NOP)) dut (
        .sclk(sclk), .srst_n(srst_n),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_ask(ref_ask), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
        .wr_ask(wr_ask), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .rd_ask(rd_ask), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .ref_pending(ref_pending),
        .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus-ownership model: who owns the bus, whether cke is up, who was served last
    int m_owner = O_INIT;
    bit m_cke   = 1'b0;
    int m_last  = O_RD;

    always @(posedge sclk or negedge srst_n) begin
        int winner;
        if (!srst_n) begin
            m_owner <= O_INIT;
            m_cke   <= 1'b0;
            m_last  <= O_RD;
        end else begin
            m_cke <= 1'b1;
            case (m_owner)
                O_INIT: if (init_end) m_owner <= O_IDLE;
                O_IDLE: begin
                    winner = O_IDLE;
                    if (ref_ask) winner = O_REF;
                    else if (wr_ask && rd_ask) winner = (RR && m_last == O_WR) ? O_RD : O_WR;
                    else if (wr_ask) winner = O_WR;
                    else if (rd_ask) winner = O_RD;
                    m_owner <= winner;
                    if (winner == O_WR || winner == O_RD) m_last <= winner;
                end
                O_REF: if (ref_end) m_owner <= O_IDLE;
                O_WR:  if (wr_end)  m_owner <= O_IDLE;
                O_RD:  if (rd_end)  m_owner <= O_IDLE;
                default: m_owner <= O_INIT;
            endcase
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge sclk) begin
        logic [3:0]  e_cmd;
        logic [11:0] e_addr;
        case (m_owner)
            O_INIT:  begin e_cmd = init_cmd; e_addr = init_addr; end
            O_REF:   begin e_cmd = ref_cmd;  e_addr = ref_addr;  end
            O_WR:    begin e_cmd = wr_cmd;   e_addr = wr_addr;   end
            O_RD:    begin e_cmd = rd_cmd;   e_addr = rd_addr;   end
            default: begin e_cmd = NOP;      e_addr = 12'd0;     end
        endcase
        check("m_ref_en", 32'(ref_en), 32'(m_owner == O_REF));
        check("m_wr_en", 32'(wr_en), 32'(m_owner == O_WR));
        check("m_rd_en", 32'(rd_en), 32'(m_owner == O_RD));
        check("m_ref_pending", 32'(ref_pending), 32'(ref_ask && (m_owner == O_WR || m_owner == O_RD)));
        check("m_cke", 32'(sdram_cke), 32'(m_cke));
        check("m_cmd", 32'(sdram_cmd), 32'(e_cmd));
        check("m_addr", 32'(sdram_addr), 32'(e_addr));
    end

    task automatic step();
        @(posedge sclk);
        #2;
    endtask

    task automatic at_neg();
        #3;
    endtask

    task automatic set_end(input int who, input logic v);
        case (who)
            O_REF:   ref_end = v;
            O_WR:    wr_end  = v;
            O_RD:    rd_end  = v;
            default: ;
        endcase
    endtask

    // Hold ownership for len cycles (counting the current one), ending with x_end
    task automatic run_owner(input int who, input int len);
        for (int k = 0; k < len; k++) begin
            if (k == len - 1) set_end(who, 1'b1);
            step();
            set_end(who, 1'b0);
        end
    endtask

    function automatic int granted();
        if (ref_en) return O_REF;
        if (wr_en)  return O_WR;
        if (rd_en)  return O_RD;
        return O_IDLE;
    endfunction

    initial begin
        int hi;
        int g;
        int exp_g;

        // Reset and init handoff
        step();
        at_neg();
        check("rst_cke", 32'(sdram_cke), 32'd0);
        check("rst_cmd", 32'(sdram_cmd), 32'h0);
        check("rst_grants", 32'({ref_en, wr_en, rd_en, ref_pending}), 32'd0);
        step();
        srst_n = 1'b1;
        at_neg();
        check("cke_cycle0", 32'(sdram_cke), 32'd0);
        step();
        at_neg();
        check("cke_cycle1", 32'(sdram_cke), 32'd1);
        for (int i = 0; i < 8; i++) step();
        at_neg();
        check("init_cmd", 32'(sdram_cmd), 32'h0);
        check("init_addr", 32'(sdram_addr), 32'h400);
        step();
        init_end = 1'b1;
        step();
        at_neg();
        check("arbit_cmd", 32'(sdram_cmd), 32'(4'b0111));
        check("arbit_addr", 32'(sdram_addr), 32'd0);

        // Single write burst of exactly 8 cycles, then a NOP gap
        step();
        wr_ask = 1'b1;
        step();
        wr_ask = 1'b0;
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) wr_end = 1'b1;
            at_neg();
            if (wr_en === 1'b1 && sdram_cmd === 4'b0100 && sdram_addr === 12'h123) hi++;
            step();
            wr_end = 1'b0;
        end
        at_neg();
        check("wr_en_cycles", 32'(hi), 32'd8);
        check("gap_wr_en", 32'(wr_en), 32'd0);
        check("gap_cmd", 32'(sdram_cmd), 32'(4'b0111));
        step();

        // All three ask together: refresh first, then the data engines
        ref_ask = 1'b1; wr_ask = 1'b1; rd_ask = 1'b1;
        step();
        at_neg();
        check("prio_first", 32'(granted()), 32'(O_REF));
        ref_ask = 1'b0;
        run_owner(O_REF, 3);
        at_neg();
        check("prio_gap", 32'(sdram_cmd), 32'(4'b0111));
        step();
        at_neg();
        // Last data grant was the write burst, so round-robin serves read next
        exp_g = RR ? O_RD : O_WR;
        check("prio_second", 32'(granted()), 32'(exp_g));
        if (exp_g == O_WR) wr_ask = 1'b0; else rd_ask = 1'b0;
        run_owner(exp_g, 2);
        step();
        at_neg();
        exp_g = RR ? O_WR : O_RD;
        check("prio_third", 32'(granted()), 32'(exp_g));
        wr_ask = 1'b0; rd_ask = 1'b0;
        run_owner(exp_g, 2);

        // Refresh arriving mid-write waits, then beats a held read ask
        wr_ask = 1'b1;
        step();
        wr_ask = 1'b0;
        rd_ask = 1'b1;
        step();
        ref_ask = 1'b1;
        at_neg();
        check("pend_1", 32'(ref_pending), 32'd1);
        step();
        at_neg();
        check("pend_2", 32'(ref_pending), 32'd1);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        at_neg();
        check("pend_arbit", 32'(ref_pending), 32'd0);
        step();
        at_neg();
        check("pend_ref_first", 32'(granted()), 32'(O_REF));
        ref_ask = 1'b0;
        run_owner(O_REF, 2);
        step();
        at_neg();
        check("pend_rd_after", 32'(granted()), 32'(O_RD));
        rd_ask = 1'b0;

        // Asynchronous reset in the middle of a read
        step();
        srst_n = 1'b0;
        #1;
        check("arst_rd_en", 32'(rd_en), 32'd0);
        check("arst_cmd", 32'(sdram_cmd), 32'h0);
        check("arst_addr", 32'(sdram_addr), 32'h400);
        step();
        step();
        srst_n = 1'b1;
        init_end = 1'b0;
        at_neg();
        check("arst_cke", 32'(sdram_cke), 32'd0);
        check("arst_init_cmd", 32'(sdram_cmd), 32'h0);
        step();
        init_end = 1'b1;
        step();

        // Write and read ask continuously
        wr_ask = 1'b1; rd_ask = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            at_neg();
            g = granted();
            exp_g = (RR && (i % 2 == 1)) ? O_RD : O_WR;
            check("rr_grant", 32'(g), 32'(exp_g));
            run_owner((g == O_RD) ? O_RD : O_WR, 2);
        end
        wr_ask = 1'b0; rd_ask = 1'b0;
        step();

        // Randomized traffic with occasional resets; the model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            srst_n    = ($urandom_range(0, 399) != 0);
            init_end  = ($urandom_range(0, 3) == 0);
            ref_ask   = ($urandom_range(0, 3) == 0);
            wr_ask    = ($urandom_range(0, 1) == 0);
            rd_ask    = ($urandom_range(0, 1) == 0);
            ref_end   = ($urandom_range(0, 4) == 0);
            wr_end    = ($urandom_range(0, 4) == 0);
            rd_end    = ($urandom_range(0, 4) == 0);
            init_cmd  = 4'($urandom);
            ref_cmd   = 4'($urandom);
            wr_cmd    = 4'($urandom);
            rd_cmd    = 4'($urandom);
            init_addr = 12'($urandom);
            ref_addr  = 12'($urandom);
            wr_addr   = 12'($urandom);
            rd_addr   = 12'($urandom);
            step();
        end
        srst_n = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command-bus arbiter for the SDRAM controller. It sequences power-up initialisation, then shares the single SDRAM command/address bus between the auto-refresh, write and read engines. It grants one engine at a time through an ask/en/end handshake and muxes the granted engine's command and address onto the device pins. It sits at the top of the controller, between the per-operation engines and the SDRAM I/O.

## Interface
Parameters:
- CMD_NOP, 4'b0111, command driven when no engine owns the bus ({cs_n, ras_n, cas_n, we_n}).

Ports:
- sclk  in  1  controller clock; everything is on the rising edge.
- srst_n  in  1  asynchronous, active-low reset.
- init_end  in  1  init engine finished; level, sampled every cycle.
- init_cmd / init_addr  in  4 / 12  init engine bus drive.
- ref_ask / ref_end  in  1 / 1  refresh request / completion pulse.
- ref_cmd / ref_addr  in  4 / 12  refresh engine bus drive.
- wr_ask / wr_end  in  1 / 1  write request / completion pulse.
- wr_cmd / wr_addr  in  4 / 12  write engine bus drive.
- rd_ask / rd_end  in  1 / 1  read request / completion pulse.
- rd_cmd / rd_addr  in  4 / 12  read engine bus drive.
- ref_en / wr_en / rd_en  out  1  grant to each engine, registered.
- ref_pending  out  1  ref_ask high while state is WRITE or READ. Engines use it to close the current burst early.
- sdram_cke  out  1  clock enable, registered.
- sdram_cmd  out  4  muxed command.
- sdram_addr  out  12  muxed address.

## Operation
- State machine states:
  - INIT: mux init_cmd/init_addr. Go to ARBIT on the cycle after init_end is sampled high.
  - ARBIT: drive CMD_NOP and address 0. Sample the asks with priority ref > wr > rd. Enter the winner's state next cycle. Stay in ARBIT if no ask.
  - AREF / WRITE / READ: mux that engine's cmd/addr. The matching x_en is high for every cycle spent in the state. Return to ARBIT the cycle after x_end is sampled high.
- No preemption. A refresh ask during WRITE/READ only raises ref_pending. The arbiter waits for wr_end/rd_end, then grants refresh at the next ARBIT cycle, ahead of any wr/rd ask.
- An engine holds x_ask until it sees x_en. An ask that drops before the grant is simply not granted.
- x_end outside the matching state is ignored.
- x_ask from the engine that just ended may be high in the same cycle as its x_end. It is evaluated normally in the following ARBIT cycle.
- sdram_cke goes from 0 to 1 one cycle after reset release and stays at 1.
- cmd/addr mux is combinational from the state register. Exactly one source drives the bus in every state.

## Timing
- Reset values:
  - state: INIT.
  - ref_en, wr_en, rd_en: 0.
  - sdram_cke: 0.
  - ref_pending: 0.
  - sdram_cmd: init_cmd (INIT mux).
- Grant latency: an ask sampled in ARBIT gives x_en = 1 and the engine's cmd on the bus in the next cycle.
- Release latency: x_end high in cycle N puts the arbiter in ARBIT in cycle N+1 (x_en = 0, NOP). The earliest next grant is cycle N+2.
- Minimum bus gap between two owners is one NOP cycle.
- Asserting srst_n low mid-operation clears all grants immediately and returns to INIT. Engines are reset by the same srst_n.

## Configuration
- SDRAM_ARB_RR_EN:
  - Defined: a last_wr flag is set on each write grant and cleared on each read grant. When wr_ask and rd_ask are both high in ARBIT with no ref_ask, the engine not served last wins. Refresh still has top priority.
  - Undefined: fixed priority ref > wr > rd, and last_wr is not built.

## Structure
- Shared package sdram_pkg: CMD_NOP and the other {cs_n, ras_n, cas_n, we_n} command encodings; state encodings INIT=5'b00001, ARBIT=5'b00010, AREF=5'b00100, WRITE=5'b01000, READ=5'b10000 (one-hot).
- No sub-module. The block is a single FSM plus an output mux. The round-robin flag is inline under the macro.

## Test plan
- Reset, then init_end high at cycle 10 -> state ARBIT at cycle 11; sdram_cmd 4'b0111; sdram_cke 1 from cycle 1.
- In ARBIT, wr_ask held; wr_end pulsed 8 cycles after wr_en -> wr_en high exactly 8 cycles with wr_cmd on the bus, then one NOP cycle.
- ref_ask, wr_ask and rd_ask all high in the same ARBIT cycle -> ref_en first; after ref_end, wr_en; after wr_end, rd_en.
- ref_ask rises mid-WRITE -> ref_pending = 1 until wr_end. ref_en is granted immediately after the ARBIT cycle even with rd_ask held.
- With SDRAM_ARB_RR_EN, wr_ask and rd_ask held continuously -> grants alternate wr, rd, wr, rd. Without the macro -> only wr is granted.
- srst_n pulled low during READ -> rd_en drops asynchronously; after release, state is INIT and the bus follows init_cmd.
